// File: rtl/call_scheduler_if.sv
// Bundle between the lift FSM / call panels and the call scheduler.
// The master side drives requests and car position; the slave side is the scheduler.
interface call_scheduler_if;
  logic [7:0] car_req;
  logic [7:0] hall_req;
  logic [2:0] cur_floor;
  logic       arrived;
  logic [2:0] target;
  logic       tgt_valid;
  logic [1:0] dir;
  logic       door_open;
  logic [7:0] pending;

  modport master (
    output car_req, hall_req, cur_floor, arrived,
    input  target, tgt_valid, dir, door_open, pending
  );

  modport slave (
    input  car_req, hall_req, cur_floor, arrived,
    output target, tgt_valid, dir, door_open, pending
  );
endinterface

// File: rtl/call_scheduler.sv
// SCAN-style elevator call scheduler: records car/hall calls, dispatches one
// target floor at a time to the lift FSM and times the door dwell.
module call_scheduler #(
  parameter int DWELL_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  call_scheduler_if.slave bus
);
  localparam int NF = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_MOVE   = 2'd2;
  localparam logic [1:0] S_DWELL  = 2'd3;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYC - 1);

  logic [1:0]    state;
  logic [NF-1:0] pending;
  logic [NF-1:0] pend_nxt;
  logic [NF-1:0] new_req;
  logic [2:0]    target;
  logic [1:0]    dir;
  logic [7:0]    dwell_cnt;

  logic          up_found, dn_found;
  logic [2:0]    up_flr, dn_flr;
  logic [2:0]    d_up, d_dn;
  logic          sel_found;
  logic [2:0]    sel_flr;
  logic [1:0]    sel_dir;
  logic          cur_req;

  assign new_req = bus.car_req | bus.hall_req;
  assign cur_req = new_req[bus.cur_floor];

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    up_found = 1'b0;
    up_flr   = '0;
    for (int i = NF-1; i >= 0; i--) begin
      if (pending[i] && (3'(i) > bus.cur_floor)) begin
        up_found = 1'b1;
        up_flr   = 3'(i);
      end
    end
    dn_found = 1'b0;
    dn_flr   = '0;
    for (int i = 0; i < NF; i++) begin
      if (pending[i] && (3'(i) < bus.cur_floor)) begin
        dn_found = 1'b1;
        dn_flr   = 3'(i);
      end
    end
  end

  assign d_up = up_flr - bus.cur_floor;
  assign d_dn = bus.cur_floor - dn_flr;

  // Keep sweeping in the current direction; reverse only when nothing lies ahead.
  always_comb begin
    sel_found = 1'b0;
    sel_flr   = '0;
    sel_dir   = dir;
    case (dir)
      DIR_UP: begin
        if (up_found) begin
          sel_found = 1'b1; sel_flr = up_flr; sel_dir = DIR_UP;
        end else if (dn_found) begin
          sel_found = 1'b1; sel_flr = dn_flr; sel_dir = DIR_DN;
        end
      end
      DIR_DN: begin
        if (dn_found) begin
          sel_found = 1'b1; sel_flr = dn_flr; sel_dir = DIR_DN;
        end else if (up_found) begin
          sel_found = 1'b1; sel_flr = up_flr; sel_dir = DIR_UP;
        end
      end
      default: begin
        if (dn_found && (!up_found || (d_dn <= d_up))) begin
          sel_found = 1'b1; sel_flr = dn_flr; sel_dir = DIR_DN;
        end else if (up_found) begin
          sel_found = 1'b1; sel_flr = up_flr; sel_dir = DIR_UP;
        end
      end
    endcase
  end

  // Per-floor call latch; clears take priority over a same-cycle request.
  for (genvar f = 0; f < NF; f++) begin : g_floor
    logic clr_arr, clr_sel, absorb;
    assign clr_arr = (state == S_MOVE) && bus.arrived && (target == 3'(f));
    assign clr_sel = (state == S_SELECT) && !sel_found && (bus.cur_floor == 3'(f));
    assign absorb  = (state == S_DWELL) && (bus.cur_floor == 3'(f));
    assign pend_nxt[f] = (clr_arr || clr_sel) ? 1'b0 :
                         absorb               ? pending[f] :
                                                (pending[f] | new_req[f]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= '0;
      target    <= '0;
      dir       <= DIR_IDLE;
      dwell_cnt <= '0;
    end else begin
      pending <= pend_nxt;
      case (state)
        S_IDLE: begin
          if (|(pending | new_req)) state <= S_SELECT;
        end
        S_SELECT: begin
          if (sel_found) begin
            target <= sel_flr;
            dir    <= sel_dir;
            state  <= S_MOVE;
          end else if (pending[bus.cur_floor]) begin
            dwell_cnt <= DWELL_LOAD;
            state     <= S_DWELL;
          end else begin
            dir   <= DIR_IDLE;
            state <= S_IDLE;
          end
        end
        S_MOVE: begin
          if (bus.arrived) begin
            dwell_cnt <= DWELL_LOAD;
            state     <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (cur_req)               dwell_cnt <= DWELL_LOAD;
          else if (dwell_cnt == 8'd0) state    <= S_SELECT;
          else                        dwell_cnt <= dwell_cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.target    = target;
  assign bus.tgt_valid = (state == S_MOVE);
  assign bus.dir       = dir;
  assign bus.door_open = (state == S_DWELL);
  assign bus.pending   = pending;
endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler: dispatch latency, SCAN ordering, tie
// breaking, same-floor calls, dwell extension and asynchronous reset.
module tb_call_scheduler;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  call_scheduler_if bus ();

  call_scheduler #(.DWELL_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lift FSM model: report arrival at floor f, then count door_open cycles.
  task automatic arrive(input logic [2:0] f, output logic tv, output int ncyc);
    bus.cur_floor = f;
    bus.arrived   = 1'b1;
    step();
    bus.arrived = 1'b0;
    tv   = bus.tgt_valid;
    ncyc = 0;
    while (bus.door_open && ncyc < 50) begin
      ncyc++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.car_req = '0; bus.hall_req = '0; bus.cur_floor = '0; bus.arrived = 1'b0;
    step(); step();
    n_cmp++; if (bus.target !== 3'd0) begin n_bad++; $display("FAIL rst_target got %0d want 0", bus.target); end
    n_cmp++; if (bus.tgt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tgt_valid got %b want 0", bus.tgt_valid); end
    n_cmp++; if (bus.dir !== 2'b00) begin n_bad++; $display("FAIL rst_dir got %b want 00", bus.dir); end
    n_cmp++; if (bus.door_open !== 1'b0) begin n_bad++; $display("FAIL rst_door got %b want 0", bus.door_open); end
    n_cmp++; if (bus.pending !== 8'h00) begin n_bad++; $display("FAIL rst_pending got %h want 00", bus.pending); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_dispatch_up();
    logic tv; int n;
    bus.cur_floor = 3'd0;
    bus.hall_req  = 8'h20;
    step();
    bus.hall_req = '0;
    n_cmp++; if (bus.pending !== 8'h20) begin n_bad++; $display("FAIL up_pending1 got %h want 20", bus.pending); end
    n_cmp++; if (bus.tgt_valid !== 1'b0) begin n_bad++; $display("FAIL up_tv_early got %b want 0", bus.tgt_valid); end
    step();
    n_cmp++; if (bus.tgt_valid !== 1'b1) begin n_bad++; $display("FAIL up_tv got %b want 1", bus.tgt_valid); end
    n_cmp++; if (bus.target !== 3'd5) begin n_bad++; $display("FAIL up_target got %0d want 5", bus.target); end
    n_cmp++; if (bus.dir !== 2'b01) begin n_bad++; $display("FAIL up_dir got %b want 01", bus.dir); end
    step(); step();
    n_cmp++; if (bus.pending !== 8'h20) begin n_bad++; $display("FAIL up_pending_hold got %h want 20", bus.pending); end
    arrive(3'd5, tv, n);
    n_cmp++; if (tv !== 1'b0) begin n_bad++; $display("FAIL up_tv_drop got %b want 0", tv); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL up_dwell got %0d want 4", n); end
    n_cmp++; if (bus.pending !== 8'h00) begin n_bad++; $display("FAIL up_pending_clr got %h want 00", bus.pending); end
    step();
    n_cmp++; if (bus.dir !== 2'b00) begin n_bad++; $display("FAIL up_idle_dir got %b want 00", bus.dir); end
    n_cmp++; if (bus.tgt_valid !== 1'b0) begin n_bad++; $display("FAIL up_idle_tv got %b want 0", bus.tgt_valid); end
  endtask

  task automatic test_scan();
    logic tv; int n;
    bus.cur_floor = 3'd2;
    bus.car_req   = 8'h20;
    step();
    bus.car_req = '0;
    step();
    n_cmp++; if (bus.target !== 3'd5 || bus.dir !== 2'b01) begin n_bad++; $display("FAIL scan_t5 got %0d/%b want 5/01", bus.target, bus.dir); end
    bus.hall_req = 8'h42;
    step();
    bus.hall_req = '0;
    n_cmp++; if (bus.pending !== 8'h62) begin n_bad++; $display("FAIL scan_pending got %h want 62", bus.pending); end
    n_cmp++; if (bus.target !== 3'd5) begin n_bad++; $display("FAIL scan_no_retarget got %0d want 5", bus.target); end
    arrive(3'd5, tv, n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL scan_dwell5 got %0d want 4", n); end
    n_cmp++; if (bus.pending !== 8'h42) begin n_bad++; $display("FAIL scan_clr5 got %h want 42", bus.pending); end
    step();
    n_cmp++; if (bus.target !== 3'd6 || bus.dir !== 2'b01 || bus.tgt_valid !== 1'b1) begin
      n_bad++; $display("FAIL scan_t6 got %0d/%b/%b want 6/01/1", bus.target, bus.dir, bus.tgt_valid); end
    arrive(3'd6, tv, n);
    step();
    n_cmp++; if (bus.target !== 3'd1 || bus.dir !== 2'b10) begin n_bad++; $display("FAIL scan_t1 got %0d/%b want 1/10", bus.target, bus.dir); end
    arrive(3'd1, tv, n);
    step();
    n_cmp++; if (bus.dir !== 2'b00 || bus.pending !== 8'h00) begin n_bad++; $display("FAIL scan_end got %b/%h want 00/00", bus.dir, bus.pending); end
  endtask

  task automatic test_tie();
    logic tv; int n;
    bus.cur_floor = 3'd4;
    bus.hall_req  = 8'h44;
    step();
    bus.hall_req = '0;
    step();
    n_cmp++; if (bus.target !== 3'd2 || bus.dir !== 2'b10) begin n_bad++; $display("FAIL tie_t2 got %0d/%b want 2/10", bus.target, bus.dir); end
    arrive(3'd2, tv, n);
    step();
    n_cmp++; if (bus.target !== 3'd6 || bus.dir !== 2'b01) begin n_bad++; $display("FAIL tie_t6 got %0d/%b want 6/01", bus.target, bus.dir); end
    arrive(3'd6, tv, n);
    step();
    n_cmp++; if (bus.dir !== 2'b00) begin n_bad++; $display("FAIL tie_end got %b want 00", bus.dir); end
  endtask

  task automatic test_cur_floor_call();
    int n;
    bus.cur_floor = 3'd3;
    bus.car_req   = 8'h08;
    step();
    bus.car_req = '0;
    n_cmp++; if (bus.pending !== 8'h08) begin n_bad++; $display("FAIL cur_pending got %h want 08", bus.pending); end
    step();
    n_cmp++; if (bus.door_open !== 1'b1 || bus.tgt_valid !== 1'b0) begin n_bad++; $display("FAIL cur_dwell got %b/%b want 1/0", bus.door_open, bus.tgt_valid); end
    n_cmp++; if (bus.pending !== 8'h00) begin n_bad++; $display("FAIL cur_clr got %h want 00", bus.pending); end
    n = 0;
    while (bus.door_open && n < 50) begin n++; step(); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL cur_dwell_len got %0d want 4", n); end
    step();
    n_cmp++; if (bus.door_open !== 1'b0 || bus.tgt_valid !== 1'b0 || bus.dir !== 2'b00) begin
      n_bad++; $display("FAIL cur_idle got %b/%b/%b want 0/0/00", bus.door_open, bus.tgt_valid, bus.dir); end
  endtask

  task automatic test_ignore_and_extend();
    int n;
    bus.cur_floor = 3'd3;
    bus.arrived   = 1'b1;
    step();
    bus.arrived = 1'b0;
    step();
    n_cmp++; if (bus.tgt_valid !== 1'b0 || bus.door_open !== 1'b0 || bus.pending !== 8'h00) begin
      n_bad++; $display("FAIL ign_arrived got %b/%b/%h want 0/0/00", bus.tgt_valid, bus.door_open, bus.pending); end
    bus.car_req = 8'h08;
    step();
    bus.car_req = '0;
    step(); step();
    bus.car_req = 8'h08;
    step();
    bus.car_req = '0;
    n_cmp++; if (bus.pending !== 8'h00) begin n_bad++; $display("FAIL ext_absorb got %h want 00", bus.pending); end
    n = 0;
    while (bus.door_open && n < 50) begin n++; step(); end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL ext_dwell got %0d want 4", n); end
    step();
  endtask

  task automatic test_reset_mid_move();
    bus.cur_floor = 3'd0;
    bus.hall_req  = 8'h80;
    bus.car_req   = 8'h01;
    step();
    bus.hall_req = '0; bus.car_req = '0;
    step();
    n_cmp++; if (bus.tgt_valid !== 1'b1 || bus.target !== 3'd7 || bus.pending !== 8'h81) begin
      n_bad++; $display("FAIL mv_setup got %b/%0d/%h want 1/7/81", bus.tgt_valid, bus.target, bus.pending); end
    step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.tgt_valid !== 1'b0 || bus.target !== 3'd0 || bus.pending !== 8'h00 ||
                 bus.dir !== 2'b00 || bus.door_open !== 1'b0) begin
      n_bad++; $display("FAIL async_rst got %b/%0d/%h/%b/%b want 0/0/00/00/0",
                        bus.tgt_valid, bus.target, bus.pending, bus.dir, bus.door_open); end
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    n_cmp++; if (bus.tgt_valid !== 1'b0 || bus.pending !== 8'h00 || bus.door_open !== 1'b0) begin
      n_bad++; $display("FAIL post_rst_quiet got %b/%h/%b want 0/00/0", bus.tgt_valid, bus.pending, bus.door_open); end
    bus.hall_req = 8'h10;
    step();
    bus.hall_req = '0;
    step();
    n_cmp++; if (bus.tgt_valid !== 1'b1 || bus.target !== 3'd4 || bus.dir !== 2'b01) begin
      n_bad++; $display("FAIL post_rst_dispatch got %b/%0d/%b want 1/4/01", bus.tgt_valid, bus.target, bus.dir); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_dispatch_up();
    test_scan();
    test_tie();
    test_cur_floor_call();
    test_ignore_and_extend();
    test_reset_mid_move();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/call_scheduler.md
CALL_SCHEDULER -- requirements
Module: call_scheduler

Interface
REQ-001 Parameter DWELL_CYC, default 4, SHALL set the door-open dwell length in clock cycles (legal range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-004 car_req  input  8  SHALL carry in-car floor button pulses, one bit per floor 0..7.
REQ-005 hall_req  input  8  SHALL carry hall call pulses, one bit per floor 0..7.
REQ-006 cur_floor  input  3  SHALL give the car's present floor, driven by the lift FSM.
REQ-007 arrived  input  1  SHALL be a one-cycle pulse from the lift FSM meaning the car has reached target.
REQ-008 target  output  3  SHALL give the floor currently dispatched to the lift FSM.
REQ-009 tgt_valid  output  1  SHALL mark target as valid and held.
REQ-010 dir  output  2  SHALL give the travel direction: 00 idle, 01 up, 10 down; 11 is never driven.
REQ-011 door_open  output  1  SHALL be high while dwelling at a floor.
REQ-012 pending  output  8  SHALL expose the registered outstanding-call vector.

Function
REQ-013 Each cycle, the block SHALL set pending[i] <= pending[i] | car_req[i] | hall_req[i], except where REQ-019 or REQ-021 clears the bit (clear wins).
REQ-014 The FSM SHALL have four states: IDLE, SELECT, MOVE, DWELL.
REQ-015 IDLE: dir=00; when (pending|car_req|hall_req) != 0, the FSM SHALL go to SELECT at the next edge, giving tgt_valid two edges after a request pulse.
REQ-016 SELECT (exactly one cycle) SHALL compute the next target by SCAN:
  - dir=01: lowest pending floor > cur_floor; if none, highest pending < cur_floor with dir<=10.
  - dir=10: highest pending floor < cur_floor; if none, lowest pending > cur_floor with dir<=01.
  - dir=00: nearest pending floor; on a distance tie, the lower floor; dir set accordingly.
  - Target found: latch target, go to MOVE.
  - Only pending[cur_floor] set: clear it, go to DWELL with dir unchanged.
  - pending==0: go to IDLE with dir<=00.
REQ-017 MOVE: tgt_valid=1 and target SHALL stay constant; new requests SHALL only update pending (no retargeting).
REQ-018 tgt_valid SHALL drop in the cycle after arrived is sampled in MOVE.
REQ-019 On arrived in MOVE, the block SHALL clear pending[target] and go to DWELL.
REQ-020 DWELL: door_open=1; a counter SHALL load DWELL_CYC-1 on entry and decrement; at 0 the FSM SHALL go to SELECT, giving exactly DWELL_CYC cycles of door_open.
REQ-021 During DWELL, a request for cur_floor SHALL be absorbed (bit not set) and the dwell counter reloaded.
REQ-022 arrived outside MOVE SHALL be ignored.
REQ-023 Simultaneous requests on several floors in one cycle SHALL all be recorded.
REQ-024 cur_floor SHALL be sampled only in SELECT and DWELL.

Reset
REQ-025 While rst_n=0, the block SHALL hold: state=IDLE, pending=0, target=0, tgt_valid=0, dir=00, door_open=0, dwell counter=0.
REQ-026 Reset asserted mid-MOVE or mid-DWELL SHALL abort immediately and discard all pending calls.
REQ-027 After rst_n deasserts, the first request SHALL be serviced per REQ-015.

Verification
REQ-028 Idle at floor 0, hall_req=0x20 pulse at cycle t: tgt_valid=1 and target=5 with dir=01 after edge t+2; pending=0x20 until arrived.
REQ-029 Car at 2 moving up to 5, pending {1,6,5}, arrived: pending[5] cleared, door_open for 4 cycles, then target=6 with dir=01; after 6, target=1 with dir=10.
REQ-030 Idle at floor 4, simultaneous calls at 2 and 6 (equal distance): target=2, dir=10.
REQ-031 Call at cur_floor=3 while idle: no tgt_valid, door_open=1 for DWELL_CYC cycles, pending returns to 0, state IDLE.
REQ-032 arrived pulsed while IDLE and car_req[cur_floor] during DWELL: no state change for the former; dwell extended by a full DWELL_CYC for the latter.
REQ-033 rst_n low during MOVE with pending=0x81: all outputs reach reset values without waiting for a clock edge; after release, no dispatch occurs until a new request arrives.
